// File: rtl/ec_range_update.sv
// AV1 entropy-encoder interval update: computes u/v from the inverse CDF, narrows
// range/low for one symbol, normalizes, and hands the result downstream.
module ec_range_update #(
    parameter int RANGE_WIDTH = 16,
    parameter int LOW_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANGE_WIDTH-1:0] in_fl,
    input  logic [RANGE_WIDTH-1:0] in_fh,
    input  logic [3:0]             in_s,
    input  logic [4:0]             in_nsyms,
    output logic [7:0]             lut_u_addr,
    input  logic [RANGE_WIDTH-1:0] lut_u_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RANGE_WIDTH-1:0] out_range,
    output logic [LOW_WIDTH-1:0]   out_low_pre,
    output logic [LOW_WIDTH-1:0]   out_low,
    output logic [SHIFT_WIDTH-1:0] out_shift
);

    localparam logic [RANGE_WIDTH-1:0] HALF = {1'b1, {(RANGE_WIDTH-1){1'b0}}};
    localparam int PW = 2*RANGE_WIDTH - 14;

    typedef enum logic [1:0] {IDLE, CALC, NORM, OUT} state_t;

    state_t state, state_nxt;

    logic [RANGE_WIDTH-1:0] range_q, fl_q, fh_q, u_q, v_q;
    logic [LOW_WIDTH-1:0]   low_q;
    logic [3:0]             s_q, n_q;

    logic [PW-1:0]          prod_u, prod_v;
    logic [RANGE_WIDTH-1:0] u_calc, v_calc;
    logic                   first_sym;
    logic [RANGE_WIDTH-1:0] r_norm, low_add, range_n;
    logic [LOW_WIDTH-1:0]   low_pre, low_n;
    logic [SHIFT_WIDTH-1:0] d_norm;

    // Leading-zero count; the highest set bit is the last one to overwrite.
    function automatic logic [SHIFT_WIDTH-1:0] lzc(input logic [RANGE_WIDTH-1:0] x);
        logic [SHIFT_WIDTH-1:0] n;
        n = SHIFT_WIDTH'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++)
            if (x[i]) n = SHIFT_WIDTH'(RANGE_WIDTH - 1 - i);
        return n;
    endfunction

    always_comb begin
        prod_u = PW'(range_q >> 8) * PW'(fl_q >> 6);
        prod_v = PW'(range_q >> 8) * PW'(fh_q >> 6);
        u_calc = RANGE_WIDTH'(prod_u >> 1) + lut_u_q;
        v_calc = RANGE_WIDTH'(prod_v >> 1) + (lut_u_q - RANGE_WIDTH'(4));
    end

    always_comb begin
        first_sym = (fl_q >= HALF);
        low_add   = range_q - u_q;
        if (first_sym) begin
            r_norm  = range_q - v_q;
            low_pre = low_q;
        end else begin
            r_norm  = u_q - v_q;
            low_pre = low_q + {{(LOW_WIDTH-RANGE_WIDTH){1'b0}}, low_add};
        end
        d_norm  = lzc(r_norm);
        range_n = r_norm << d_norm;
        low_n   = low_pre << d_norm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!init && in_valid) state_nxt = CALC;
            CALC:    state_nxt = NORM;
            NORM:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        lut_u_addr = {n_q, s_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            range_q     <= HALF;
            low_q       <= '0;
            fl_q        <= '0;
            fh_q        <= '0;
            s_q         <= '0;
            n_q         <= '0;
            u_q         <= '0;
            v_q         <= '0;
            out_valid   <= 1'b0;
            out_range   <= '0;
            out_low_pre <= '0;
            out_low     <= '0;
            out_shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        range_q <= HALF;
                        low_q   <= '0;
                    end else if (in_valid) begin
                        fl_q <= in_fl;
                        fh_q <= in_fh;
                        s_q  <= in_s;
                        n_q  <= 4'(in_nsyms - 5'd1);
                    end
                end
                CALC: begin
                    u_q <= u_calc;
                    v_q <= v_calc;
                end
                NORM: begin
                    range_q     <= range_n;
                    low_q       <= low_n;
                    out_range   <= range_n;
                    out_low_pre <= low_pre;
                    out_low     <= low_n;
                    out_shift   <= d_norm;
                    out_valid   <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_range_update.sv
// Randomized bench for ec_range_update against an arithmetic model of the
// interval update, plus directed reset/init/back-pressure scenarios.
module tb_ec_range_update;

    logic        clk = 1'b0;
    logic        reset, init, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_fl, in_fh, lut_u_q, out_range;
    logic [3:0]  in_s;
    logic [4:0]  in_nsyms, out_shift;
    logic [7:0]  lut_u_addr;
    logic [23:0] out_low_pre, out_low;

    always #5 clk = ~clk;

    ec_range_update dut (
        .clk(clk), .reset(reset), .init(init),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fl(in_fl), .in_fh(in_fh), .in_s(in_s), .in_nsyms(in_nsyms),
        .lut_u_addr(lut_u_addr), .lut_u_q(lut_u_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_range(out_range), .out_low_pre(out_low_pre),
        .out_low(out_low), .out_shift(out_shift)
    );

    // Minimum-probability LUT: 4*(N-s+1)
    assign lut_u_q = 16'(4 * (int'(lut_u_addr[7:4]) - int'(lut_u_addr[3:0]) + 1));

    int n_vec = 0, n_err = 0;
    longint m_range = 32768, m_low = 0;
    int obs_range, obs_pre, obs_low, obs_shift;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int nsyms, input int s, input int fl, input int fh,
                         output int e_range, output int e_pre, output int e_low, output int e_d);
        longint a, u, v, r, pre;
        int lut;
        lut = 4 * (nsyms - 1 - s + 1);
        a = m_range / 256;
        u = (a * (fl / 64)) / 2 + lut;
        v = (a * (fh / 64)) / 2 + lut - 4;
        if (fl < 32768) begin
            r   = u - v;
            pre = m_low + (m_range - u);
        end else begin
            r   = m_range - v;
            pre = m_low;
        end
        pre = pre & 64'hFFFFFF;
        e_d = 0;
        while (r > 0 && (r << e_d) < 32768) e_d++;
        m_range = r << e_d;
        m_low   = (pre << e_d) & 64'hFFFFFF;
        e_range = int'(m_range);
        e_pre   = int'(pre);
        e_low   = int'(m_low);
    endtask

    task automatic send(input int nsyms, input int s, input int fl, input int fh,
                        input int hold, input bit init_in_calc);
        int er, ep, el, ed, cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1; in_nsyms = 5'(nsyms); in_s = 4'(s);
        in_fl = 16'(fl); in_fh = 16'(fh);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lut_addr", 32'(lut_u_addr), 32'(((nsyms - 1) << 4) | s));
        chk("in_ready_busy", 32'(in_ready), 0);
        if (init_in_calc) init = 1'b1;
        model(nsyms, s, fl, fh, er, ep, el, ed);
        cyc = 1;
        while (!out_valid && cyc < 10) begin @(negedge clk); init = 1'b0; cyc++; end
        init = 1'b0;
        chk("latency", 32'(cyc), 3);
        if (!out_valid) return;
        obs_range = int'(out_range); obs_pre = int'(out_low_pre);
        obs_low = int'(out_low); obs_shift = int'(out_shift);
        chk("out_range", 32'(out_range), 32'(er));
        chk("out_low_pre", 32'(out_low_pre), 32'(ep));
        chk("out_low", 32'(out_low), 32'(el));
        chk("out_shift", 32'(out_shift), 32'(ed));
        for (int i = 0; i < hold; i++) begin
            // garbage offered while busy must be ignored
            in_valid = 1'b1; in_fl = 16'($urandom); in_fh = 16'($urandom);
            in_s = 4'($urandom); in_nsyms = 5'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_range", 32'(out_range), 32'(er));
            chk("hold_low", 32'(out_low), 32'(el));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_range = 32768; m_low = 0;
        @(negedge clk);
    endtask

    initial begin
        int nsyms, s, fl, fh;
        reset = 1'b1; init = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fl = '0; in_fh = '0; in_s = '0; in_nsyms = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_range", 32'(out_range), 0);
        chk("rst_out_low", 32'(out_low), 0);
        chk("rst_lut_addr", 32'(lut_u_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // first symbol of a binary alphabet
        send(2, 0, 32768, 16384, 0, 0);
        chk("t1_range", 32'(obs_range), 65520);
        chk("t1_pre", 32'(obs_pre), 0);
        chk("t1_low", 32'(obs_low), 0);
        chk("t1_shift", 32'(obs_shift), 2);

        do_reset();
        send(2, 1, 16384, 0, 0, 0);
        chk("t2_range", 32'(obs_range), 32776);
        chk("t2_pre", 32'(obs_pre), 16380);
        chk("t2_low", 32'(obs_low), 32760);
        chk("t2_shift", 32'(obs_shift), 1);

        // back-to-back with back-pressure on the first result
        do_reset();
        send(2, 0, 32768, 16384, 5, 0);
        send(2, 1, 16384, 0, 0, 0);

        // init in IDLE wins over in_valid; init during CALC is ignored
        send(4, 2, 12000, 3000, 1, 0);
        send(8, 7, 900, 0, 0, 0);
        init = 1'b1; in_valid = 1'b1; in_nsyms = 5'd2; in_s = 4'd0;
        in_fl = 16'd32768; in_fh = 16'd16384;
        @(negedge clk);
        init = 1'b0; in_valid = 1'b0;
        chk("init_stay_idle", 32'(in_ready), 1);
        repeat (3) @(negedge clk);
        chk("init_no_out", 32'(out_valid), 0);
        m_range = 32768; m_low = 0;
        send(2, 0, 32768, 16384, 0, 0);
        chk("t4_range", 32'(obs_range), 65520);
        chk("t4_low", 32'(obs_low), 0);
        send(2, 0, 32768, 16384, 0, 1);

        // reset while the symbol is in NORM
        send(3, 1, 20000, 5000, 0, 0);
        in_valid = 1'b1; in_nsyms = 5'd2; in_s = 4'd1; in_fl = 16'd16384; in_fh = 16'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_range", 32'(out_range), 0);
        chk("mid_rst_low", 32'(out_low), 0);
        chk("mid_rst_pre", 32'(out_low_pre), 0);
        chk("mid_rst_shift", 32'(out_shift), 0);
        @(negedge clk);
        reset = 1'b0;
        m_range = 32768; m_low = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_rst_no_out", 32'(out_valid), 0);
        end
        send(2, 0, 32768, 16384, 0, 0);
        chk("t5_range", 32'(obs_range), 65520);

        // random legal symbols; low wraps mod 2^24 along the way
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(19, 0) == 0) begin
                init = 1'b1;
                @(negedge clk);
                init = 1'b0;
                m_range = 32768; m_low = 0;
            end
            nsyms = int'($urandom_range(16, 2));
            s     = int'($urandom_range(nsyms - 1, 0));
            fl    = (s == 0) ? 32768 : int'($urandom_range(32767, 0));
            if (s == nsyms - 1) fh = 0;
            else fh = int'($urandom_range((s == 0) ? 32767 : fl, 0));
            send(nsyms, s, fl, fh, int'($urandom_range(2, 0)), 1'($urandom_range(7, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
